// File: rtl/cxu_rsp_buffer.sv
// cxu_rsp_buffer: in-order response FIFO placed between a combinational CXU
// and the CPU's CXU response port. in_ready drives the CXU's rsp_ready, so a
// full buffer stalls the CXU and, through cmd_ready, the CPU.
// Optional same-cycle pass-through when empty: define CXU_RSP_BUFFER_BYPASS_EN.
module cxu_rsp_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_payload_outputs_0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_payload_outputs_0,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;

  logic [ADDR_W-1:0] wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [ADDR_W:0]   count_next;

  logic              full_int;
  logic              stored_valid;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  wr_en;

  assign full_int     = (count_reg == DEPTH_CNT);
  // Reset masks everything so the CXU and CPU see an idle, empty buffer.
  assign stored_valid = !reset && (count_reg != '0);

`ifdef CXU_RSP_BUFFER_BYPASS_EN
  // Empty buffer with a ready consumer: hand the word straight through.
  assign bypass = !reset && !clear && (count_reg == '0) && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = !reset && !full_int;
  // A bypassed word is consumed in flight: no array write, no state change.
  assign push      = in_valid && in_ready && !bypass;
  assign pop       = stored_valid && out_ready;

  assign out_valid = stored_valid || bypass;
  assign count     = reset ? '0 : count_reg;
  assign full      = !reset && full_int;
  assign empty     = reset || (count_reg == '0);

  // Output word: head of the queue, the bypassed input, or zero when idle.
  always_comb begin
    out_payload_outputs_0 = '0;
    if (stored_valid)
      out_payload_outputs_0 = mem_reg[rd_ptr_reg];
    else if (bypass)
      out_payload_outputs_0 = in_payload_outputs_0;
  end

  // One write-enable per entry, decoded from the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && !clear && (wr_ptr_reg == ADDR_W'(gi));
    end
  endgenerate

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push)
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state; reset overrides clear and any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i] && !reset)
        mem_reg[i] <= in_payload_outputs_0;
    end
  end

endmodule

// File: tb/tb_cxu_rsp_buffer.sv
// Directed testbench for cxu_rsp_buffer (DEPTH=4, DATA_W=32).
// Works with and without CXU_RSP_BUFFER_BYPASS_EN defined.
module tb_cxu_rsp_buffer;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_payload_outputs_0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_payload_outputs_0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  cxu_rsp_buffer #(.DEPTH(4), .DATA_W(32)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .clear                 (clear),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_payload_outputs_0  (in_payload_outputs_0),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_payload_outputs_0 (out_payload_outputs_0),
    .count                 (count),
    .full                  (full),
    .empty                 (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_payload_outputs_0 = '0;
    tick(); tick();

    // During reset
    in_valid = 1'b1; out_ready = 1'b1; in_payload_outputs_0 = 32'h55;
    #1;
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_payload",   out_payload_outputs_0, 32'd0);
    chk("rst_empty",     32'(empty), 32'd1);
    chk("rst_full",      32'(full), 32'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_count",    32'(count), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_payload",  out_payload_outputs_0, 32'd0);
    $display("reset/idle done");

    // Two pushes, then drain in order
    in_valid = 1'b1; in_payload_outputs_0 = 32'h0000_0006;
    tick();
    chk("lat1_out_valid", 32'(out_valid), 32'd1);
    chk("lat1_payload",   out_payload_outputs_0, 32'h0000_0006);
    in_payload_outputs_0 = 32'hFFFF_FFFA;
    tick();
    in_valid = 1'b0;
    chk("two_count",   32'(count), 32'd2);
    chk("two_head",    out_payload_outputs_0, 32'h0000_0006);
    out_ready = 1'b1;
    tick();
    $display("pop 0x00000006");
    chk("two_pop1",    out_payload_outputs_0, 32'hFFFF_FFFA);
    chk("two_cnt1",    32'(count), 32'd1);
    tick();
    $display("pop 0xfffffffa");
    chk("two_empty",   32'(empty), 32'd1);
    chk("two_ov0",     32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Fill to full, blocked push, then wrap
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_payload_outputs_0 = 32'(i);
      tick();
      $display("push %0d", i);
    end
    in_payload_outputs_0 = 32'd5;
    #1;
    chk("fill_full",     32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count",    32'(count), 32'd4);
    tick();
    chk("blocked_count", 32'(count), 32'd4);
    chk("blocked_head",  out_payload_outputs_0, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("pop1_count",    32'(count), 32'd3);
    chk("pop1_head",     out_payload_outputs_0, 32'd2);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("wrap_count",    32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("wrap_out%0d", i), out_payload_outputs_0, 32'(i));
      tick();
      $display("pop %0d", i);
    end
    chk("wrap_empty",    32'(empty), 32'd1);
    out_ready = 1'b0;

    // Steady simultaneous push/pop at count=2
    in_valid = 1'b1;
    in_payload_outputs_0 = 32'h100; tick();
    in_payload_outputs_0 = 32'h101; tick();
    chk("ss_count0", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_payload_outputs_0 = 32'h102 + 32'(k);
      #1;
      chk($sformatf("ss_out%0d", k), out_payload_outputs_0, 32'h100 + 32'(k));
      tick();
      chk($sformatf("ss_cnt%0d", k), 32'(count), 32'd2);
    end
    out_ready = 1'b0;
    chk("ss_head_end", out_payload_outputs_0, 32'h106);

    // Clear at count=3 with push and pop in the same cycle
    in_payload_outputs_0 = 32'h108; tick();
    chk("pre_clr_count", 32'(count), 32'd3);
    clear = 1'b1; in_payload_outputs_0 = 32'hDEAD_BEEF; out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_count",     32'(count), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_payload",   out_payload_outputs_0, 32'd0);
    in_valid = 1'b1; in_payload_outputs_0 = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("post_clr_payload", out_payload_outputs_0, 32'h1234_5678);
    chk("post_clr_count",   32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    $display("pop 0x12345678");
    chk("post_clr_empty",   32'(empty), 32'd1);
    out_ready = 1'b0;

    // Reset mid-stream discards entries
    in_valid = 1'b1;
    in_payload_outputs_0 = 32'hA1; tick();
    in_payload_outputs_0 = 32'hA2; tick();
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ov",    32'(out_valid), 32'd0);
    in_valid = 1'b1; in_payload_outputs_0 = 32'hB7; tick(); in_valid = 1'b0;
    chk("midrst_first", out_payload_outputs_0, 32'hB7);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("midrst_empty", 32'(empty), 32'd1);

    // Empty buffer, in_valid and out_ready together
    in_valid = 1'b1; out_ready = 1'b1; in_payload_outputs_0 = 32'h0000_002A;
    #1;
`ifdef CXU_RSP_BUFFER_BYPASS_EN
    chk("byp_out_valid", 32'(out_valid), 32'd1);
    chk("byp_payload",   out_payload_outputs_0, 32'h2A);
    tick();
    in_valid = 1'b0;
    #1;
    chk("byp_count",     32'(count), 32'd0);
    chk("byp_ov_after",  32'(out_valid), 32'd0);
`else
    chk("nobyp_out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("nobyp_ov_next", 32'(out_valid), 32'd1);
    chk("nobyp_payload", out_payload_outputs_0, 32'h2A);
    tick();
    chk("nobyp_empty",   32'(empty), 32'd1);
`endif
    $display("transfer 0x0000002a");
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
